dm_responder: RTL and testbench
===============================

# dm_responder

Memory-side responder for the CPU's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and performs byte, half-word and word accesses on an internal word array. It returns the sign- or zero-extended load data, or a store acknowledge, after a fixed, configurable latency. It sits between the datapath's memory-access stage and the data storage, and replaces the zero-latency combinational DM once the core moves to a stalling multi-cycle interface.

## Interface
Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in the array; index = req_addr[31:2] modulo DEPTH_WORDS
- LATENCY, 2, cycles from the accept edge to the first cycle of rsp_valid; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state and the array
- req_valid  in  1  request present
- req_ready  out  1  responder can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  access type (DMOp encoding, see Operation)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  misaligned access (only meaningful with DM_MISALIGN_CHECK_EN; tied 0 otherwise)

## Operation
- req_op encoding: 0 word, 1 byte unsigned, 2 byte signed, 3 half unsigned, 4 half signed; 5-7 behave as word.
- FSM states:
  - IDLE: req_ready=1; on req_valid go to WAIT, or to RESP if LATENCY=1.
  - WAIT: decrement counter; on reaching 1 go to RESP.
  - RESP: rsp_valid=1; hold until rsp_ready, then go to IDLE.
- Accept edge = rising clk with req_valid & req_ready.
  - Store: byte lanes are merged into the word at the accept edge.
  - Load: the extracted, extended value is registered at the accept edge and held stable through RESP.
- Lane selection:
  - byte uses addr[1:0], lane 0 = bits 7:0.
  - half uses addr[1], 0 = bits 15:0.
  - Sign extension uses the selected lane's MSB.
- Back-to-back accesses are not possible: req_ready stays low from the accept edge until the cycle after the response handshake.
  - Minimum period is LATENCY+1 cycles.
- A load issued after a store to the same word returns the stored data.
- Request inputs are ignored outside IDLE.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, counter=0, all array words 0.
- Accept at edge T:
  - rsp_valid rises after edge T+LATENCY-1, so it is first sampled high at edge T+LATENCY.
  - Response completes at the first edge with rsp_valid & rsp_ready.
  - req_ready is high again in the following cycle.
- rsp_ready held high continuously gives total occupancy of LATENCY+1 cycles per request.
- Reset asserted mid-WAIT or mid-RESP: the pending response is dropped and outputs take their reset values immediately (asynchronously). A store already merged at its accept edge is lost with the array clear.
- rsp_ready asserted while rsp_valid=0 has no effect.

## Configuration
- DM_MISALIGN_CHECK_EN defined:
  - Word access needs addr[1:0]=0 and half access needs addr[0]=0.
  - On violation: no array write, rsp_rdata=0, rsp_err=1 for that response, same latency as a normal access.
- DM_MISALIGN_CHECK_EN undefined:
  - No check. Word access ignores addr[1:0]; half access ignores addr[0].
  - rsp_err is tied to 0.

## Structure
- Package dm_pkg holds:
  - DMOp constants (DM_WORD, DM_BU, DM_B, DM_HU, DM_H)
  - the FSM state typedef (IDLE, WAIT, RESP)
  - the LATENCY counter width constant (4)
- One sub-module, dm_lane (combinational):
  - Store path: old word + wdata + op + addr[1:0] gives the merged word.
  - Load path: word + op + addr[1:0] gives the extended rdata.
  - With DM_MISALIGN_CHECK_EN it also outputs the misalign flag.

## Test plan
- Reset, then store word 0x12345678 at addr 0x10, then load word at 0x10 -> rsp_rdata=0x12345678. rsp_valid is first sampled at accept+2 (LATENCY=2).
- After the above, store byte 0xAB (op 1) at 0x13, then load op 2 at 0x13 -> 0xFFFFFFAB; load op 1 -> 0x000000AB; load word at 0x10 -> 0xAB345678.
- Store half 0x8001 at 0x22, then load op 4 -> 0xFFFF8001, load op 3 -> 0x00008001, load word at 0x20 -> 0x80010000.
- Hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid and rsp_rdata are stable and req_ready=0 throughout. Pulse reset low in the middle -> rsp_valid=0 and req_ready=1 immediately, and a load of the same address returns 0.
- With DM_MISALIGN_CHECK_EN, store word to 0x21 -> rsp_err=1. A following load of word 0x20 returns the prior value, unchanged. Without the macro, the same store writes word 0x20.
- LATENCY=1 build: accept at edge T -> rsp_valid sampled high at T+1. With rsp_ready tied high, accepts occur every 2 cycles.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: access-type codes,
// FSM state type and latency counter width.
package dm_pkg;

    localparam logic [2:0] DM_WORD = 3'd0;
    localparam logic [2:0] DM_BU   = 3'd1;
    localparam logic [2:0] DM_B    = 3'd2;
    localparam logic [2:0] DM_HU   = 3'd3;
    localparam logic [2:0] DM_H    = 3'd4;

    localparam int DM_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dm_state_e;

endpackage

// File: rtl/dm_responder_if.sv
// Request/response bundle between the memory-access stage (master) and
// the data-memory responder (slave).
interface dm_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dm_lane.sv
// Byte/half/word lane steering: store merge and extended load extraction.
// Adds a misalignment flag when DM_MISALIGN_CHECK_EN is defined.
module dm_lane
    import dm_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] merged_o,
`ifdef DM_MISALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic [31:0] rdata_o
);

    logic [4:0]  byte_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_sh = {addr_lo_i, 3'b000};
    assign byte_v  = old_word_i[byte_sh +: 8];
    assign half_v  = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        merged_o = old_word_i;
        rdata_o  = old_word_i;
        unique case (op_i)
            DM_BU, DM_B: begin
                merged_o[byte_sh +: 8] = wdata_i[7:0];
                rdata_o = (op_i == DM_B) ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
            end
            DM_HU, DM_H: begin
                if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
                else              merged_o[15:0]  = wdata_i[15:0];
                rdata_o = (op_i == DM_H) ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
            end
            default: begin
                merged_o = wdata_i;
                rdata_o  = old_word_i;
            end
        endcase
    end

`ifdef DM_MISALIGN_CHECK_EN
    always_comb begin
        unique case (op_i)
            DM_BU, DM_B: misalign_o = 1'b0;
            DM_HU, DM_H: misalign_o = addr_lo_i[0];
            default:     misalign_o = (addr_lo_i != 2'b00);
        endcase
    end
`endif

endmodule

// File: rtl/dm_responder.sv
// Fixed-latency data-memory responder over a valid/ready handshake.
// Optional misaligned-access checking is enabled by DM_MISALIGN_CHECK_EN.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 3072,
    parameter int LATENCY     = 2
) (
    input  logic           clk,
    input  logic           reset,
    dm_responder_if.slave  bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]         mem_q [DEPTH_WORDS];
    dm_state_e           state_q;
    logic [DM_CNT_W-1:0] cnt_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_rdata_q;

    logic [AW-1:0] idx;
    logic [31:0]   old_word;
    logic [31:0]   merged_word;
    logic [31:0]   load_data;
    logic          misalign;
    logic          accept;

    // Word index wraps modulo the array depth, which need not be a power of two.
    assign idx      = AW'(bus.req_addr[31:2] % 30'(DEPTH_WORDS));
    assign old_word = mem_q[idx];
    assign accept   = bus.req_valid && req_ready_q;

    dm_lane u_lane (
        .old_word_i (old_word),
        .wdata_i    (bus.req_wdata),
        .op_i       (bus.req_op),
        .addr_lo_i  (bus.req_addr[1:0]),
        .merged_o   (merged_word),
`ifdef DM_MISALIGN_CHECK_EN
        .misalign_o (misalign),
`endif
        .rdata_o    (load_data)
    );

`ifdef DM_MISALIGN_CHECK_EN
    logic rsp_err_q;
    assign bus.rsp_err = rsp_err_q;
`else
    assign misalign    = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef DM_MISALIGN_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        rsp_rdata_q <= (bus.req_we || misalign) ? 32'h0 : load_data;
`ifdef DM_MISALIGN_CHECK_EN
                        rsp_err_q   <= misalign;
`endif
                        if (LATENCY == 1) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            cnt_q       <= '0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= DM_CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q <= DM_CNT_W'(1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the array is cleared by reset because a dropped store must not
    // survive it; this costs a reset path on every word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (accept && bus.req_we && !misalign) begin
            mem_q[idx] <= merged_word;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: LATENCY=2 instance for the access tests,
// LATENCY=1 instance for the back-to-back throughput test.
module tb_dm_responder;
    import dm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

`ifdef DM_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    dm_responder_if bus1();
    dm_responder_if bus2();

    dm_responder #(.DEPTH_WORDS(3072), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    dm_responder #(.DEPTH_WORDS(3072), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    // One complete transaction on the LATENCY=2 instance; returns what was seen.
    task automatic access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                          output int lat, output logic rdy_after);
        int n;
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_op = op;
        bus1.req_addr = addr; bus1.req_wdata = wdata;
        n = 0;
        while (!bus1.req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk); lat++;
            if (bus1.rsp_valid) break;
        end
        if (!bus1.rsp_valid) lat = -1;
        rd = bus1.rsp_rdata; er = bus1.rsp_err;
        bus1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus1.rsp_ready = 1'b0;
        rdy_after = bus1.req_ready;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus1.req_valid = 0; bus1.req_we = 0; bus1.req_op = 0; bus1.req_addr = 0;
        bus1.req_wdata = 0; bus1.rsp_ready = 0;
        bus2.req_valid = 0; bus2.req_we = 0; bus2.req_op = 0; bus2.req_addr = 0;
        bus2.req_wdata = 0; bus2.rsp_ready = 0;
        repeat (3) @(negedge clk);
        checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got %b want 1", bus1.req_ready); end
        checks++; if (bus1.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid got %b want 0", bus1.rsp_valid); end
        checks++; if (bus1.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset rsp_rdata got %h want 0", bus1.rsp_rdata); end
        checks++; if (bus1.rsp_err !== 1'b0) begin errors++; $display("FAIL reset rsp_err got %b want 0", bus1.rsp_err); end
        checks++; if (bus2.req_ready !== 1'b1 || bus2.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_l1 ready/valid got %b/%b want 1/0", bus2.req_ready, bus2.rsp_valid);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        logic        we[3]  = '{1'b1, 1'b0, 1'b0};
        logic [31:0] ad[3]  = '{32'h10, 32'h10, 32'h3010};
        logic [31:0] exp[3] = '{32'h0, 32'h12345678, 32'h12345678};
        logic [31:0] rd; logic er, ra; int lat; exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{exp[i], 1'b0, 2});
            access(we[i], DM_WORD, ad[i], 32'h12345678, rd, er, lat, ra);
            e = sb.pop_front();
            checks++; if (rd !== e.rdata) begin errors++; $display("FAIL word[%0d] rdata got %h want %h", i, rd, e.rdata); end
            checks++; if (er !== e.err) begin errors++; $display("FAIL word[%0d] err got %b want %b", i, er, e.err); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL word[%0d] latency got %0d want %0d", i, lat, e.lat); end
            checks++; if (ra !== 1'b1) begin errors++; $display("FAIL word[%0d] req_ready after got %b want 1", i, ra); end
        end
    endtask

    task automatic test_byte();
        logic        we[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  op[4]  = '{DM_BU, DM_B, DM_BU, DM_WORD};
        logic [31:0] ad[4]  = '{32'h13, 32'h13, 32'h13, 32'h10};
        logic [31:0] exp[4] = '{32'h0, 32'hFFFFFFAB, 32'h000000AB, 32'hAB345678};
        logic [31:0] rd; logic er, ra; int lat; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{exp[i], 1'b0, 2});
            access(we[i], op[i], ad[i], 32'h000000AB, rd, er, lat, ra);
            e = sb.pop_front();
            checks++; if (rd !== e.rdata) begin errors++; $display("FAIL byte[%0d] rdata got %h want %h", i, rd, e.rdata); end
            checks++; if (lat !== e.lat || er !== e.err) begin
                errors++; $display("FAIL byte[%0d] lat/err got %0d/%b want %0d/%b", i, lat, er, e.lat, e.err);
            end
        end
    endtask

    task automatic test_half();
        logic        we[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [2:0]  op[5]  = '{DM_HU, DM_H, DM_HU, DM_WORD, 3'd7};
        logic [31:0] ad[5]  = '{32'h22, 32'h22, 32'h22, 32'h20, 32'h20};
        logic [31:0] exp[5] = '{32'h0, 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'h80010000};
        logic [31:0] rd; logic er, ra; int lat; exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{exp[i], 1'b0, 2});
            access(we[i], op[i], ad[i], 32'h00008001, rd, er, lat, ra);
            e = sb.pop_front();
            checks++; if (rd !== e.rdata) begin errors++; $display("FAIL half[%0d] rdata got %h want %h", i, rd, e.rdata); end
            checks++; if (lat !== e.lat || er !== e.err) begin
                errors++; $display("FAIL half[%0d] lat/err got %0d/%b want %0d/%b", i, lat, er, e.lat, e.err);
            end
        end
    endtask

    task automatic test_misalign();
        logic        we[3]  = '{1'b1, 1'b0, 1'b0};
        logic [2:0]  op[3]  = '{DM_WORD, DM_WORD, DM_HU};
        logic [31:0] ad[3]  = '{32'h21, 32'h20, 32'h21};
        logic [31:0] exp[3];
        logic        eer[3];
        logic [31:0] rd; logic er, ra; int lat; exp_t e;
        exp[0] = 32'h0; eer[0] = CHK;
        exp[1] = CHK ? 32'h80010000 : 32'hDEADBEEF; eer[1] = 1'b0;
        exp[2] = CHK ? 32'h0 : 32'h0000BEEF;        eer[2] = CHK;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{exp[i], eer[i], 2});
            access(we[i], op[i], ad[i], 32'hDEADBEEF, rd, er, lat, ra);
            e = sb.pop_front();
            checks++; if (rd !== e.rdata) begin errors++; $display("FAIL misalign[%0d] rdata got %h want %h", i, rd, e.rdata); end
            checks++; if (er !== e.err) begin errors++; $display("FAIL misalign[%0d] err got %b want %b", i, er, e.err); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL misalign[%0d] latency got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_stall_reset();
        int n;
        logic [31:0] rd; logic er, ra; int lat; exp_t e;
        sb.push_back('{32'hAB345678, 1'b0, 2});
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_op = DM_WORD; bus1.req_addr = 32'h10;
        n = 0;
        while (!bus1.req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        n = 0;
        while (!bus1.rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (bus1.rsp_valid !== 1'b1) begin errors++; $display("FAIL stall rsp_valid timeout got %b want 1", bus1.rsp_valid); end
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus1.rsp_valid !== 1'b1 || bus1.req_ready !== 1'b0) begin
                errors++; $display("FAIL stall[%0d] valid/ready got %b/%b want 1/0", i, bus1.rsp_valid, bus1.req_ready);
            end
            checks++; if (bus1.rsp_rdata !== e.rdata) begin errors++; $display("FAIL stall[%0d] rdata got %h want %h", i, bus1.rsp_rdata, e.rdata); end
        end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus1.rsp_valid !== 1'b0 || bus1.req_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset valid/ready got %b/%b want 0/1", bus1.rsp_valid, bus1.req_ready);
        end
        checks++; if (bus1.rsp_rdata !== 32'h0) begin errors++; $display("FAIL async_reset rdata got %h want 0", bus1.rsp_rdata); end
        @(negedge clk); reset = 1'b1;
        sb.push_back('{32'h0, 1'b0, 2});
        access(1'b0, DM_WORD, 32'h10, 32'h0, rd, er, lat, ra);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL post_reset rdata got %h want %h", rd, e.rdata); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL post_reset latency got %0d want %0d", lat, e.lat); end
    endtask

    task automatic test_back_to_back();
        logic        we[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  op[5]  = '{DM_WORD, DM_WORD, DM_BU, DM_WORD, DM_B};
        logic [31:0] ad[5]  = '{32'h100, 32'h100, 32'h101, 32'h100, 32'h101};
        logic [31:0] wd[5]  = '{32'hCAFEF00D, 32'h0, 32'h00000080, 32'h0, 32'h0};
        logic [31:0] exp[5] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFE800D, 32'hFFFFFF80};
        int acc_q[$];
        int idx = 0, nrsp = 0, cyc = 0, prev = -1;
        logic acc, hs;
        exp_t e;
        @(negedge clk);
        bus2.rsp_ready = 1'b1;
        bus2.req_valid = 1'b1; bus2.req_we = we[0]; bus2.req_op = op[0];
        bus2.req_addr = ad[0]; bus2.req_wdata = wd[0];
        while ((idx < 5 || nrsp < 5) && cyc < 60) begin
            acc = bus2.req_valid && bus2.req_ready;
            hs  = bus2.rsp_valid && bus2.rsp_ready;
            if (hs) begin
                e = sb.pop_front();
                nrsp++;
                checks++; if (bus2.rsp_rdata !== e.rdata) begin
                    errors++; $display("FAIL b2b rsp[%0d] rdata got %h want %h", nrsp - 1, bus2.rsp_rdata, e.rdata);
                end
                checks++; if (cyc - acc_q[0] !== e.lat) begin
                    errors++; $display("FAIL b2b rsp[%0d] latency got %0d want %0d", nrsp - 1, cyc - acc_q[0], e.lat);
                end
                void'(acc_q.pop_front());
            end
            if (acc) begin
                if (prev >= 0) begin
                    checks++; if (cyc - prev !== 2) begin
                        errors++; $display("FAIL b2b accept spacing got %0d want 2", cyc - prev);
                    end
                end
                prev = cyc;
                acc_q.push_back(cyc);
                sb.push_back('{exp[idx], 1'b0, 1});
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 5) begin
                    bus2.req_we = we[idx]; bus2.req_op = op[idx];
                    bus2.req_addr = ad[idx]; bus2.req_wdata = wd[idx];
                end else begin
                    bus2.req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        checks++; if (nrsp !== 5) begin errors++; $display("FAIL b2b response count got %0d want 5", nrsp); end
        bus2.rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_stall_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
